mcp_ctrl: RTL and testbench

Multicycle main controller for the MIPS-subset processor. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives the unified instruction/data memory's write enable and address select, the IR and PC enables, the register-file write, and all datapath mux selects. An embedded ALU decoder turns opcode and funct into the 3-bit ALU control.

---
 rtl/mcp_pkg.sv | 46 ++++
 rtl/mcp_alu_dec.sv | 36 +++
 rtl/mcp_ctrl.sv | 151 +++++++++++++++
 tb/tb_mcp_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mcp_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset controller.
package mcp_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mcp_alu_dec.sv
// ALU decoder: maps the controller's ALUOp and the R-type funct field to the
// 3-bit ALU control; flags funct codes outside the supported set.
module mcp_alu_dec
  import mcp_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct_i6,
  output logic [2:0]  alu_ctrl_o3,
  output logic        bad_funct
);

  always_comb begin
    alu_ctrl_o3 = ALU_ADD;
    bad_funct   = 1'b0;
    case (aluop)
      ALUOP_ADD: alu_ctrl_o3 = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o3 = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i6)
          FN_ADD:  alu_ctrl_o3 = ALU_ADD;
          FN_SUB:  alu_ctrl_o3 = ALU_SUB;
          FN_AND:  alu_ctrl_o3 = ALU_AND;
          FN_OR:   alu_ctrl_o3 = ALU_OR;
          FN_SLT:  alu_ctrl_o3 = ALU_SLT;
          // Unknown funct still executes as an add so the instruction completes.
          default: begin
            alu_ctrl_o3 = ALU_ADD;
            bad_funct   = 1'b1;
          end
        endcase
      end
      default: alu_ctrl_o3 = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcp_ctrl.sv
// Multicycle Moore main controller for the MIPS-subset processor.
// Optional bne support is enabled by defining MCP_BNE_EN.
module mcp_ctrl
  import mcp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] op_i6,
  input  logic [5:0] funct_i6,
  input  logic       zero_i,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_we_o,
  output logic       pc_en_o,
  output logic       rf_we_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o2,
  output logic [1:0] pc_src_o2,
  output logic [2:0] alu_ctrl_o3,
  output logic [3:0] state_o4,
  output logic       illegal_o
);

  state_t state, state_nxt;
  aluop_t aluop;
  logic   mem_we, ir_we, pc_write, branch, branch_ne, rf_we;
  logic   bad_op, bad_funct, illegal_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_FETCH;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                            illegal_q <= 1'b0;
    else if (bad_op || (state == S_RTYPEEX && bad_funct))   illegal_q <= 1'b1;
  end

  always_comb begin
    state_nxt    = S_FETCH;
    mem_we       = 1'b0;
    iord_o       = 1'b0;
    ir_we        = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    branch_ne    = 1'b0;
    rf_we        = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o2 = 2'b00;
    pc_src_o2    = 2'b00;
    aluop        = ALUOP_ADD;
    bad_op       = 1'b0;
    case (state)
      S_FETCH: begin
        ir_we        = 1'b1;
        alu_src_b_o2 = 2'b01;
        pc_write     = 1'b1;
        state_nxt    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_o2 = 2'b11;
        case (op_i6)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_RTYPEEX;
          OP_BEQ:       state_nxt = S_BEQEX;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JEX;
`ifdef MCP_BNE_EN
          OP_BNE:       state_nxt = S_BNEEX;
`endif
          default: begin
            state_nxt = S_FETCH;
            bad_op    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = 2'b10;
        state_nxt    = (op_i6 == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_o    = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we        = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEMWR: begin
        iord_o = 1'b1;
        mem_we = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a_o = 1'b1;
        aluop       = ALUOP_FUNCT;
        state_nxt   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        rf_we     = 1'b1;
        reg_dst_o = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a_o = 1'b1;
        aluop       = ALUOP_SUB;
        pc_src_o2   = 2'b01;
        branch      = 1'b1;
      end
`ifdef MCP_BNE_EN
      S_BNEEX: begin
        alu_src_a_o = 1'b1;
        aluop       = ALUOP_SUB;
        pc_src_o2   = 2'b01;
        branch      = 1'b1;
        branch_ne   = 1'b1;
      end
`endif
      S_ADDIEX: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = 2'b10;
        state_nxt    = S_ADDIWB;
      end
      S_ADDIWB: rf_we = 1'b1;
      S_JEX: begin
        pc_src_o2 = 2'b10;
        pc_write  = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  mcp_alu_dec u_alu_dec (
    .aluop       (aluop),
    .funct_i6    (funct_i6),
    .alu_ctrl_o3 (alu_ctrl_o3),
    .bad_funct   (bad_funct)
  );

  // Write strobes are gated by reset so an asserting reset kills them at once.
  assign mem_we_o  = mem_we & rst_ni;
  assign ir_we_o   = ir_we  & rst_ni;
  assign rf_we_o   = rf_we  & rst_ni;
  assign pc_en_o   = (pc_write | (branch & (zero_i ^ branch_ne))) & rst_ni;
  assign state_o4  = state;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_mcp_ctrl.sv
// Self-checking bench for mcp_ctrl: directed instructions, a reset abort in
// MEMWR, then randomized instructions against an instruction-level model.
module tb_mcp_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [5:0] op_i6, funct_i6;
  logic       zero_i;
  logic       mem_we_o, iord_o, ir_we_o, pc_en_o, rf_we_o, reg_dst_o;
  logic       mem_to_reg_o, alu_src_a_o, illegal_o;
  logic [1:0] alu_src_b_o2, pc_src_o2;
  logic [2:0] alu_ctrl_o3;
  logic [3:0] state_o4;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  bit ill_m  = 1'b0;

  typedef struct packed {
    logic       mem_we, iord, ir_we, pc_en, rf_we, reg_dst, m2r, asa;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
  } exp_t;

  mcp_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .op_i6(op_i6), .funct_i6(funct_i6),
    .zero_i(zero_i), .mem_we_o(mem_we_o), .iord_o(iord_o), .ir_we_o(ir_we_o),
    .pc_en_o(pc_en_o), .rf_we_o(rf_we_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o2(alu_src_b_o2), .pc_src_o2(pc_src_o2),
    .alu_ctrl_o3(alu_ctrl_o3), .state_o4(state_o4), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction -> sequence of states it visits (cycles per instruction).
  function automatic void seq_for(input logic [5:0] op, output int q[$]);
    case (op)
      6'b100011: q = '{0, 1, 2, 3, 4};
      6'b101011: q = '{0, 1, 2, 5};
      6'b000000: q = '{0, 1, 6, 7};
      6'b000100: q = '{0, 1, 8};
      6'b001000: q = '{0, 1, 9, 10};
      6'b000010: q = '{0, 1, 11};
`ifdef MCP_BNE_EN
      6'b000101: q = '{0, 1, 12};
`endif
      default:   q = '{0, 1};
    endcase
  endfunction

  function automatic logic [2:0] funct_ctrl(input logic [5:0] f, output bit bad);
    bad = 1'b0;
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default: begin bad = 1'b1; return 3'b010; end
    endcase
  endfunction

  function automatic exp_t exp_for(input int s, input logic [5:0] f, input logic z);
    exp_t e;
    bit   b;
    e = '0;
    e.alu = 3'b010;
    case (s)
      0:  begin e.ir_we = 1; e.asb = 2'b01; e.pc_en = 1; end
      1:  e.asb = 2'b11;
      2:  begin e.asa = 1; e.asb = 2'b10; end
      3:  e.iord = 1;
      4:  begin e.rf_we = 1; e.m2r = 1; end
      5:  begin e.iord = 1; e.mem_we = 1; end
      6:  begin e.asa = 1; e.alu = funct_ctrl(f, b); end
      7:  begin e.rf_we = 1; e.reg_dst = 1; end
      8:  begin e.asa = 1; e.alu = 3'b110; e.pcs = 2'b01; e.pc_en = z; end
      9:  begin e.asa = 1; e.asb = 2'b10; end
      10: e.rf_we = 1;
      11: begin e.pcs = 2'b10; e.pc_en = 1; end
      12: begin e.asa = 1; e.alu = 3'b110; e.pcs = 2'b01; e.pc_en = ~z; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    int q[$];
    seq_for(op, q);
    return q.size() > 2;
  endfunction

  task automatic check_all(input string ctx, input int s, input exp_t e);
    chk({ctx, ":state"},   8'(state_o4),     8'(s));
    chk({ctx, ":mem_we"},  8'(mem_we_o),     8'(e.mem_we));
    chk({ctx, ":iord"},    8'(iord_o),       8'(e.iord));
    chk({ctx, ":ir_we"},   8'(ir_we_o),      8'(e.ir_we));
    chk({ctx, ":pc_en"},   8'(pc_en_o),      8'(e.pc_en));
    chk({ctx, ":rf_we"},   8'(rf_we_o),      8'(e.rf_we));
    chk({ctx, ":reg_dst"}, 8'(reg_dst_o),    8'(e.reg_dst));
    chk({ctx, ":m2r"},     8'(mem_to_reg_o), 8'(e.m2r));
    chk({ctx, ":src_a"},   8'(alu_src_a_o),  8'(e.asa));
    chk({ctx, ":src_b"},   8'(alu_src_b_o2), 8'(e.asb));
    chk({ctx, ":pc_src"},  8'(pc_src_o2),    8'(e.pcs));
    chk({ctx, ":alu"},     8'(alu_ctrl_o3),  8'(e.alu));
    chk({ctx, ":illegal"}, 8'(illegal_o),    8'(ill_m));
  endtask

  // Reset-state expectation: FETCH decode with all write strobes low.
  function automatic exp_t reset_exp();
    exp_t e;
    e = exp_for(0, 6'd0, 1'b0);
    e.ir_we = 0; e.pc_en = 0;
    return e;
  endfunction

  // Called in the FETCH cycle just after a falling edge; returns likewise.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] f, input logic z, input int abort_at);
    int q[$];
    bit bad;
    logic [2:0] unused;
    seq_for(op, q);
    foreach (q[i]) begin
      op_i6 = op; funct_i6 = f; zero_i = z;
      #1;
      check_all($sformatf("%s/c%0d", name, i), q[i], exp_for(q[i], f, z));
      if (q[i] == abort_at) begin
        rst_ni = 1'b0;
        ill_m  = 1'b0;
        #1;
        check_all({name, "/abort"}, 0, reset_exp());
        @(negedge clk_i);
        check_all({name, "/abort_hold"}, 0, reset_exp());
        rst_ni = 1'b1;
        return;
      end
      if (q[i] == 1 && !op_known(op)) ill_m = 1'b1;
      if (q[i] == 6) begin
        unused = funct_ctrl(f, bad);
        if (bad) ill_m = 1'b1;
      end
      @(negedge clk_i);
    end
  endtask

  logic [5:0] ops [7];
  logic [5:0] fns [5];

  initial begin
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst_ni = 1'b0; op_i6 = 6'b100011; funct_i6 = 6'd0; zero_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_all($sformatf("reset%0d", i), 0, reset_exp());
    end
    rst_ni = 1'b1;

    run_instr("lw",       6'b100011, 6'd0,      1'b0, -1);
    run_instr("sw",       6'b101011, 6'd0,      1'b0, -1);
    run_instr("slt",      6'b000000, 6'b101010, 1'b0, -1);
    run_instr("beq_t",    6'b000100, 6'd0,      1'b1, -1);
    run_instr("beq_n",    6'b000100, 6'd0,      1'b0, -1);
    run_instr("bne_t",    6'b000101, 6'd0,      1'b0, -1);
    run_instr("bne_n",    6'b000101, 6'd0,      1'b1, -1);
    run_instr("addi",     6'b001000, 6'd0,      1'b0, -1);
    run_instr("j",        6'b000010, 6'd0,      1'b0, -1);
    run_instr("badfn",    6'b000000, 6'b000111, 1'b0, -1);
    run_instr("after_fn", 6'b000000, 6'b100000, 1'b0, -1);
    run_instr("sw_abort", 6'b101011, 6'd0,      1'b0, 5);
    run_instr("badop",    6'b111111, 6'd0,      1'b0, -1);
    run_instr("sticky",   6'b100011, 6'd0,      1'b1, -1);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, f;
      int r;
      r  = $urandom_range(0, 7);
      op = (r == 7) ? 6'($urandom) : ops[r];
      r  = $urandom_range(0, 5);
      f  = (r == 5) ? 6'($urandom) : fns[r];
      run_instr($sformatf("rnd%0d", n), op, f, 1'($urandom), -1);
      if (n == 30) run_instr("rnd_abort", 6'b101011, f, 1'b0, 5);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
